// File: rtl/k2red_ln_unscale.sv
// K2-RED output unscaler: y = x * 2^(2M) mod Q by iterated modular doubling.
// Optional K2RED_UNSCALE_RADIX4_EN: two chained doublings per clock (M RUN cycles).
module k2red_ln_unscale #(
  parameter int W = 32,
  parameter int M = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x,
  input  logic [W-1:0] Q,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y
);

`ifdef K2RED_UNSCALE_RADIX4_EN
  localparam int STEPS = M;
`else
  localparam int STEPS = 2 * M;
`endif
  localparam int            CW   = $clog2(STEPS + 1);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [W-1:0]  r_r;
  logic [W-1:0]  r_q;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  w_pre;
  logic [W-1:0]  w_step1;
  logic [W-1:0]  w_step;

  // One modular doubling: 2a is kept at W+1 bits so the carry is never lost.
  function automatic logic [W-1:0] dbl_step(input logic [W-1:0] a, input logic [W-1:0] m);
    logic [W:0] t;
    t = {a, 1'b0};
    if (t >= {1'b0, m}) t = t - {1'b0, m};
    return t[W-1:0];
  endfunction

  assign w_pre   = (x >= Q) ? x - Q : x;
  assign w_step1 = dbl_step(r_r, r_q);
`ifdef K2RED_UNSCALE_RADIX4_EN
  assign w_step  = dbl_step(w_step1, r_q);
`else
  assign w_step  = w_step1;
`endif

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign y         = r_r;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: the default assignment comes first so no path leaves w_next
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)       w_next = S_RUN;
      S_RUN:   if (r_cnt == LAST)  w_next = S_DONE;
      S_DONE:  if (out_ready)      w_next = S_IDLE;
      default:                     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_r   <= '0;
      r_q   <= '0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_q   <= Q;
            r_r   <= w_pre;
            r_cnt <= '0;
          end
        end
        S_RUN: begin
          r_r   <= w_step;
          r_cnt <= r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_k2red_ln_unscale.sv
// Directed bench for k2red_ln_unscale: small W=8/M=4 instance plus a W=32/M=17 instance.
module tb_k2red_ln_unscale;

`ifdef K2RED_UNSCALE_RADIX4_EN
  localparam int LAT8  = 4;
  localparam int LAT32 = 17;
`else
  localparam int LAT8  = 8;
  localparam int LAT32 = 34;
`endif
  localparam logic [7:0]  Q8  = 8'd97;
  localparam logic [31:0] Q32 = 32'hC000_0001;  // 3*2^30+1

  localparam logic [7:0] VX [5] = '{8'd0, 8'd2, 8'd96, 8'd102, 8'd5};
  localparam logic [7:0] VY [5] = '{8'd0, 8'd27, 8'd35, 8'd19, 8'd19};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0;
  logic [7:0]  a_x = '0, a_q = '0, a_y;
  logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0;
  logic [31:0] b_x = '0, b_q = '0, b_y;

  int n_vec  = 0;
  int n_fail = 0;

  k2red_ln_unscale #(.W(8), .M(4)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .x(a_x), .Q(a_q), .out_valid(a_out_valid), .out_ready(a_out_ready), .y(a_y));

  k2red_ln_unscale #(.W(32), .M(17)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .x(b_x), .Q(b_q), .out_valid(b_out_valid), .out_ready(b_out_ready), .y(b_y));

  // Independent reference: (x mod q) * (2^34 mod q) mod q in 64-bit arithmetic.
  function automatic logic [31:0] ref32(input logic [31:0] xv, input logic [31:0] qv);
    longint unsigned xr, p;
    xr = 64'(xv) % 64'(qv);
    p  = (64'd1 << 34) % 64'(qv);
    return 32'((xr * p) % 64'(qv));
  endfunction

  task automatic a_send(input logic [7:0] xv);
    a_x = xv; a_q = Q8; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic a_wait(output int cyc);
    cyc = 0;
    while (a_out_valid !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic a_pop;
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
  endtask

  task automatic b_send(input logic [31:0] xv);
    b_x = xv; b_q = Q32; b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
  endtask

  task automatic b_wait(output int cyc);
    cyc = 0;
    while (b_out_valid !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic test_reset;
    #1;
    n_vec++;
    if ({a_in_ready, a_out_valid, a_y} !== {1'b1, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL reset_a: rdy=%b vld=%b y=%0d, want rdy=1 vld=0 y=0", a_in_ready, a_out_valid, a_y);
    end
    n_vec++;
    if ({b_in_ready, b_out_valid, b_y} !== {1'b1, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_b: rdy=%b vld=%b y=%0d, want rdy=1 vld=0 y=0", b_in_ready, b_out_valid, b_y);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if ({a_in_ready, a_out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL idle_after_reset: rdy=%b vld=%b, want rdy=1 vld=0", a_in_ready, a_out_valid);
    end
  endtask

  task automatic test_basic;
    int cyc;
    a_send(8'd1);
    a_wait(cyc);
    n_vec++;
    if (cyc !== LAT8) begin
      n_fail++;
      $display("FAIL latency_x1: got %0d cycles, want %0d", cyc, LAT8);
    end
    n_vec++;
    if (a_y !== 8'd62) begin
      n_fail++;
      $display("FAIL y_x1: got %0d, want 62", a_y);
    end
    a_pop();
    // 36 is k^2 mod 97, so 36 * 2^8 must unscale to exactly 1.
    a_send(8'd36);
    a_wait(cyc);
    n_vec++;
    if (a_y !== 8'd1 || cyc !== LAT8) begin
      n_fail++;
      $display("FAIL y_x36: got y=%0d after %0d cycles, want 1 after %0d", a_y, cyc, LAT8);
    end
    a_pop();
  endtask

  task automatic test_vectors;
    int cyc;
    for (int i = 0; i < 5; i++) begin
      a_send(VX[i]);
      a_wait(cyc);
      n_vec++;
      if (a_y !== VY[i] || cyc !== LAT8) begin
        n_fail++;
        $display("FAIL vec_x%0d: got y=%0d after %0d cycles, want %0d after %0d",
                 VX[i], a_y, cyc, VY[i], LAT8);
      end
      a_pop();
    end
  endtask

  task automatic test_backpressure;
    int cyc;
    a_send(8'd2);
    a_wait(cyc);
    for (int i = 0; i < 10; i++) begin
      n_vec++;
      if ({a_out_valid, a_in_ready, a_y} !== {1'b1, 1'b0, 8'd27}) begin
        n_fail++;
        $display("FAIL hold_%0d: vld=%b rdy=%b y=%0d, want vld=1 rdy=0 y=27",
                 i, a_out_valid, a_in_ready, a_y);
      end
      @(posedge clk); #1;
    end
    // Release with a new operand already offered: DONE must not accept it.
    a_out_ready = 1'b1; a_in_valid = 1'b1; a_x = 8'd1; a_q = Q8;
    #1;
    n_vec++;
    if (a_in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL no_same_cycle_accept: rdy=%b, want 0", a_in_ready);
    end
    @(posedge clk); #1;
    a_out_ready = 1'b0; a_in_valid = 1'b0;
    n_vec++;
    if ({a_out_valid, a_in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL release: vld=%b rdy=%b, want vld=0 rdy=1", a_out_valid, a_in_ready);
    end
  endtask

  task automatic test_reset_mid_run;
    int cyc;
    a_send(8'd2);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({a_in_ready, a_out_valid, a_y} !== {1'b1, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL reset_mid_run: rdy=%b vld=%b y=%0d, want rdy=1 vld=0 y=0", a_in_ready, a_out_valid, a_y);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    a_send(8'd1);
    a_wait(cyc);
    n_vec++;
    if (a_y !== 8'd62 || cyc !== LAT8) begin
      n_fail++;
      $display("FAIL after_reset_x1: got y=%0d after %0d cycles, want 62 after %0d", a_y, cyc, LAT8);
    end
    a_pop();
  endtask

  task automatic test_back_to_back;
    int          cyc;
    logic [31:0] xv, exp;
    for (int i = 0; i < 24; i++) begin
      case (i)
        0:       xv = 32'd0;
        1:       xv = 32'd1;
        2:       xv = Q32 - 32'd1;
        3:       xv = Q32;
        4:       xv = 32'hFFFF_FFFF;
        default: xv = $urandom;
      endcase
      exp = ref32(xv, Q32);
      n_vec++;
      if (b_in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_ready_%0d: rdy=%b, want 1", i, b_in_ready);
      end
      b_send(xv);
      // Junk on x, Q and in_valid during RUN must be ignored.
      b_q = $urandom | 32'd1; b_x = $urandom; b_in_valid = 1'b1;
      b_wait(cyc);
      b_in_valid = 1'b0;
      n_vec++;
      if (b_y !== exp || cyc !== LAT32) begin
        n_fail++;
        $display("FAIL b2b_%0d x=%h: got y=%h after %0d cycles, want %h after %0d",
                 i, xv, b_y, cyc, exp, LAT32);
      end
      b_out_ready = 1'b1;
      @(posedge clk); #1;
      b_out_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/k2red_ln_unscale.md
# k2red_ln_unscale

Sequential converter that removes the k² scaling factor left by the K2-RED (Longa–Naehrig) reduction pipeline for Proth primes q = k·2^M + 1. Because k·2^M ≡ −1 (mod q), k⁻² ≡ 2^(2M) (mod q), so the block computes y = x·2^(2M) mod q by iterated modular doubling, with no multiplier. It sits on the output side of the K2-RED modular multiplier and returns results to the standard (unscaled) domain. Valid/ready handshakes are used on both sides.

## Interface
- W, 32, datapath width; Q < 2^W
- M, 17, Proth exponent of q = k·2^M + 1; number of doublings is 2·M
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operand valid
- in_ready  output  1  block can accept an operand (high only in IDLE)
- x  input  W  operand, required range [0, 2Q)
- Q  input  W  modulus, odd, 3 ≤ Q < 2^W; sampled with x on acceptance
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- y  output  W  result x·2^(2M) mod Q, range [0, Q)

## Operation
- FSM states: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: in_ready=1. When in_valid && in_ready at an edge: latch Q into q_r; load r = (x ≥ Q) ? x − Q : x; clear cnt; go RUN.
- RUN: each edge performs one doubling step: t = 2·r (W+1 bits, no overflow loss); r = (t ≥ q_r) ? t − q_r : t. cnt increments by one. After the 2·M-th step, go DONE.
- cnt width: ceil(log2(2·M+1)) bits; comparison uses the constant 2·M − 1 for the last step.
- DONE: out_valid=1, y = r (held stable). When out_ready is high at an edge, go IDLE. in_ready rises on the following cycle; there is no same-cycle accept in DONE.
- x, Q and in_valid are ignored outside IDLE; changes to Q during RUN do not affect the result.
- x ≥ 2Q violates the input contract; the result is unspecified, but the FSM still completes and returns to IDLE normally.
- Reset asserted in any state: immediate return to IDLE, with out_valid=0, in_ready=1, y=0, r=0, cnt=0. Any in-flight operand is discarded.

## Timing
- Reset values: in_ready=1, out_valid=0, y=0.
- Latency: with acceptance at edge e0, out_valid is high after edge e(2M); W=32, M=17 gives 34 cycles. Latency is fixed and independent of the data.
- Throughput: one operand per 2M+2 cycles when out_ready is held high (accept, 2M RUN cycles, 1 DONE cycle).
- out_valid stays high and y stays unchanged until the out_ready handshake.
- Critical path per step: a W+1-bit subtract and a mux.

## Configuration
- K2RED_UNSCALE_RADIX4_EN defined: each RUN edge performs two chained doubling steps (t1 from r, then t2 from t1, each with its own conditional subtract). RUN lasts M edges, so latency is M cycles and throughput is one operand per M+2 cycles. cnt counts to M−1.
- Not defined: one doubling per edge, latency 2M.
- Results are bit-identical in both modes.

## Test plan
- W=8, M=4, Q=97 (k=6): x=1 → y=62 (2^8 mod 97), out_valid after exactly 8 cycles (4 with K2RED_UNSCALE_RADIX4_EN). Also check 36·62 mod 97 = 1.
- Same configuration: x=0 → 0; x=2 → 27; x=96 → 35. Q is held at 97 for all three.
- Pre-reduction: x=102 (in [Q, 2Q)) → y=19, the same result as x=5.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. y must stay stable and in_ready must stay 0. On release, check the handshake, then in_ready=1 on the next cycle.
- Reset mid-RUN: assert rst at step 3. Outputs must go to their reset values immediately. A new operand x=1 must still give y=62 with full latency.
- Randomized check at W=32, M=17, Q=3·2^30+1 scaled to range: compare against a reference model of x·2^(2M) mod Q, including back-to-back operands and Q toggled during RUN, which must be ignored.
